tick_prescaler: RTL and testbench
=================================

// Module: tick_prescaler
// PURPOSE
// - Parametrised per-second timebase for the alarm clock, generalising the fixed 48 MHz seconds counter.
// - Emits the 1 Hz increment pulse and a half-period pulse, plus a 50% blink level and a free-running display-scan tick.
// - Supports pause (run low), fast-set mode and phase realignment.
// - Feeds the seconds/minutes/hours chain and the display driver.
// PARAMETERS
// - CLK_HZ     48_000_000  input clock frequency in Hz
// - TICK_HZ    1           inc pulse rate in normal mode
// - FAST_MULT  16          rate multiplier while fast is high
// - SCAN_HZ    1000        display-scan tick rate
// - DIV = CLK_HZ/TICK_HZ; FAST_DIV = DIV/FAST_MULT; SCAN_DIV = CLK_HZ/SCAN_HZ
// - CNT_W = $clog2(DIV); SCAN_W = $clog2(SCAN_DIV)
// - Elaboration $error unless all of these hold:
//   - DIV, FAST_DIV and SCAN_DIV are exact integers
//   - FAST_DIV is even and >= 2
//   - FAST_MULT >= 1
// PORTS
// - clk         in   1      system clock
// - reset_sync  in   1      synchronous, active-high reset
// - run         in   1      1 = main counter advances; 0 = hold (paused)
// - fast        in   1      1 = terminal is FAST_DIV-1 instead of DIV-1
// - realign     in   1      synchronous clear of main phase (seconds restart)
// - inc         out  1      one-cycle pulse, once per period
// - half_tick   out  1      one-cycle pulse at mid-period
// - blink       out  1      toggles on inc and on half_tick (50% duty)
// - scan_tick   out  1      one-cycle pulse every SCAN_DIV cycles; ignores run/fast/realign
// - count       out  CNT_W  current main-counter phase
// BEHAVIOUR
// - Reset values: count=0, scan count=0, blink=1, inc=half_tick=scan_tick=0.
// - Priority per clock edge: reset_sync > realign > run.
// - Terminal selection (combinational, takes effect the same cycle fast changes):
//   - TERM = fast ? FAST_DIV-1 : DIV-1
//   - HALF = fast ? FAST_DIV/2-1 : DIV/2-1
// - inc = run & ~realign & (count >= TERM). Combinational from registers, no added latency.
// - Next count:
//   - reset_sync or realign -> 0
//   - else if !run -> hold
//   - else if count >= TERM -> 0 (wrap)
//   - else count+1
// - The >= compare covers fast asserting while count > FAST_DIV-1: wrap and inc occur on that same cycle.
// - half_tick = run & ~realign & (count == HALF).
// - blink toggles on the edge after inc or half_tick. realign and reset force blink=1.
// - Paused (run=0):
//   - count frozen; inc, half_tick and blink frozen
//   - scan_tick keeps running
// - Resume continues from the frozen count (no phase loss).
// - realign mid-period: no inc is emitted for the truncated period. The next inc comes TERM+1 cycles after realign deasserts (with run=1).
// - scan counter: 0..SCAN_DIV-1, wraps; scan_tick = (scan_cnt == SCAN_DIV-1). Cleared only by reset_sync.
// - Widths: all compares at CNT_W/SCAN_W; +1 is width-extended and truncated; no overflow is reachable.
// STRUCTURE
// - Shared package alarm_pkg holds:
//   - CLK_HZ_DEFAULT (48_000_000)
//   - typedef enum {MODE_HOLD, MODE_RUN, MODE_FAST} tb_mode_e (decoded from run/fast, exported for debug)
//   - helper function div_ok(num, den) used by the elaboration checks
// - One sub-module, mod_counter #(W): enable, clear and terminal input; outputs cnt and at_term.
// - tick_prescaler instantiates mod_counter twice:
//   - main: enable=run, clear=reset|realign, terminal=TERM
//   - scan: enable=1, clear=reset, terminal=SCAN_DIV-1
// - Top level adds the half/blink logic.
// TESTING (bench params: CLK_HZ=48, TICK_HZ=1, FAST_MULT=4, SCAN_HZ=12 -> DIV=48, FAST_DIV=12, SCAN_DIV=4)
// 1. Reset then run=1 for 200 cycles:
//    - inc at cycles 47, 95, 143, 191
//    - half_tick at 23, 71, ...
//    - blink=1 until the edge after cycle 23, then toggles every 24 cycles
//    - scan_tick every 4th cycle
// 2. run=0 at count=30 for 50 cycles:
//    - count stays 30; no inc/half_tick; blink unchanged
//    - scan_tick continues every 4 cycles
//    - after resume, inc comes 17 cycles later
// 3. fast=1 with count=20 (>11): inc the same cycle, count->0 next cycle, then inc every 12 cycles. fast=0 restores the 48-cycle period.
// 4. realign at count=40: count->0, blink=1, no inc for the truncated period; next inc 48 cycles after realign.
// 5. reset_sync mid-period with realign=run=fast=1: all outputs take their reset values the next cycle. Reset wins over realign.
// 6. realign and count==TERM in the same cycle: inc stays 0, count->0 (realign priority).

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared constants, run-mode decode type and divider sanity helper for the alarm clock.
package alarm_pkg;
    localparam int CLK_HZ_DEFAULT = 48_000_000;
    typedef enum logic [1:0] {MODE_HOLD, MODE_RUN, MODE_FAST} tb_mode_e;
    function automatic bit div_ok(int num, int den);
        return (den > 0) ? (num % den == 0) : 1'b0;
    endfunction
endpackage

// File: rtl/tick_prescaler_if.sv
// tick_if: control inputs and timebase outputs of the tick prescaler.
interface tick_if #(parameter int CNT_W = 26);
    import alarm_pkg::*;
    logic             run;
    logic             fast;
    logic             realign;
    logic             inc;
    logic             half_tick;
    logic             blink;
    logic             scan_tick;
    logic [CNT_W-1:0] count;
    tb_mode_e         mode;
    modport master (output run, fast, realign, input inc, half_tick, blink, scan_tick, count, mode);
    modport slave  (input run, fast, realign, output inc, half_tick, blink, scan_tick, count, mode);
endinterface

// File: rtl/tick_prescaler_mod_counter.sv
// mod_counter: enabled modulo counter that wraps once it reaches or passes a runtime terminal.
module mod_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         en_i,
    input  logic         clr_i,
    input  logic [W-1:0] term_i,
    output logic [W-1:0] cnt_o,
    output logic         at_term_o
);
    logic [W-1:0] cnt_q, cnt_d;
    assign at_term_o = cnt_q >= term_i;
    assign cnt_d = clr_i ? '0 : !en_i ? cnt_q : at_term_o ? '0 : cnt_q + W'(1);
    assign cnt_o = cnt_q;
    always_ff @(posedge clk) cnt_q <= cnt_d;
endmodule

// File: rtl/tick_prescaler.sv
// tick_prescaler: per-second timebase with half-period pulse, blink level and free-running scan tick.
module tick_prescaler
    import alarm_pkg::*;
#(
    parameter int CLK_HZ    = CLK_HZ_DEFAULT,
    parameter int TICK_HZ   = 1,
    parameter int FAST_MULT = 16,
    parameter int SCAN_HZ   = 1000
) (
    input logic clk,
    input logic reset_sync,
    tick_if.slave bus
);
    localparam int DIV      = CLK_HZ / TICK_HZ;
    localparam int FAST_DIV = DIV / ((FAST_MULT < 1) ? 1 : FAST_MULT);
    localparam int SCAN_DIV = CLK_HZ / SCAN_HZ;
    localparam int CNT_W    = $clog2(DIV);
    localparam int SCAN_W   = $clog2(SCAN_DIV);

    if (!div_ok(CLK_HZ, TICK_HZ) || !div_ok(DIV, FAST_MULT) || !div_ok(CLK_HZ, SCAN_HZ) ||
        FAST_DIV % 2 != 0 || FAST_DIV < 2 || FAST_MULT < 1) begin : g_bad_params
        $error("tick_prescaler: divider parameters are not exact or FAST_DIV is not even and >= 2");
    end

    logic [CNT_W-1:0]  term, half, cnt;
    logic [SCAN_W-1:0] scan_cnt;
    logic              at_term, scan_at_term, active, blink_q, blink_d;

    assign term   = bus.fast ? CNT_W'(FAST_DIV - 1) : CNT_W'(DIV - 1);
    assign half   = bus.fast ? CNT_W'(FAST_DIV / 2 - 1) : CNT_W'(DIV / 2 - 1);
    assign active = bus.run & ~bus.realign;

    mod_counter #(.W(CNT_W)) u_main (
        .clk      (clk),
        .en_i     (bus.run),
        .clr_i    (reset_sync | bus.realign),
        .term_i   (term),
        .cnt_o    (cnt),
        .at_term_o(at_term)
    );

    mod_counter #(.W(SCAN_W)) u_scan (
        .clk      (clk),
        .en_i     (1'b1),
        .clr_i    (reset_sync),
        .term_i   (SCAN_W'(SCAN_DIV - 1)),
        .cnt_o    (scan_cnt),
        .at_term_o(scan_at_term)
    );

    assign bus.inc       = active & at_term;
    assign bus.half_tick = active & (cnt == half);
    assign bus.scan_tick = scan_at_term & (scan_cnt == SCAN_W'(SCAN_DIV - 1));
    assign bus.count     = cnt;
    assign bus.blink     = blink_q;
    assign bus.mode      = !bus.run ? MODE_HOLD : bus.fast ? MODE_FAST : MODE_RUN;

    // inc and half_tick are already gated by run, so a paused blink stays frozen
    assign blink_d = (reset_sync | bus.realign) ? 1'b1 : blink_q ^ (bus.inc | bus.half_tick);

    always_ff @(posedge clk) blink_q <= blink_d;
endmodule

// File: tb/tb_tick_prescaler.sv
// tb_tick_prescaler: directed scenarios plus randomized control, checked every cycle against a phase model.
module tb_tick_prescaler;
    import alarm_pkg::*;

    logic clk = 1'b0;
    logic reset_sync;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    tick_if #(.CNT_W(6)) bus ();

    tick_prescaler #(.CLK_HZ(48), .TICK_HZ(1), .FAST_MULT(4), .SCAN_HZ(12)) dut (
        .clk       (clk),
        .reset_sync(reset_sync),
        .bus       (bus)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // model: phase within the current period, blink level, and cycles since reset modulo 4
    int p = 0, s = 0, term, half;
    bit b = 1'b1, live = 1'b0, e_inc, e_half;
    tb_mode_e e_mode;

    always @(negedge clk) begin
        term   = bus.fast ? 11 : 47;
        half   = bus.fast ? 5 : 23;
        e_inc  = bus.run && !bus.realign && p >= term;
        e_half = bus.run && !bus.realign && p == half;
        e_mode = !bus.run ? MODE_HOLD : bus.fast ? MODE_FAST : MODE_RUN;
        if (live) begin
            chk("inc", int'(bus.inc), int'(e_inc));
            chk("half_tick", int'(bus.half_tick), int'(e_half));
            chk("blink", int'(bus.blink), int'(b));
            chk("scan_tick", int'(bus.scan_tick), int'(s == 3));
            chk("count", int'(bus.count), p);
            chk("mode", int'(bus.mode), int'(e_mode));
        end
        if (reset_sync) begin
            p = 0; b = 1'b1; s = 0; live = 1'b1;
        end else begin
            s = (s + 1) % 4;
            if (bus.realign) begin
                p = 0; b = 1'b1;
            end else if (bus.run) begin
                if (e_inc || e_half) b = !b;
                p = (p >= term) ? 0 : p + 1;
            end
        end
    end

    initial begin
        reset_sync = 1'b1; bus.run = 1'b0; bus.fast = 1'b0; bus.realign = 1'b0;
        step(1);
        reset_sync = 1'b0; bus.run = 1'b1;
        @(negedge clk);
        chk("rst_count", int'(bus.count), 0);
        chk("rst_blink", int'(bus.blink), 1);
        chk("rst_inc", int'(bus.inc), 0);
        step(23); @(negedge clk);
        chk("half_at_23", int'(bus.half_tick), 1);
        chk("blink_before_half", int'(bus.blink), 1);
        step(1); @(negedge clk);
        chk("blink_after_half", int'(bus.blink), 0);
        step(23); @(negedge clk);
        chk("inc_at_47", int'(bus.inc), 1);
        step(1); @(negedge clk);
        chk("wrap_count", int'(bus.count), 0);
        chk("blink_after_inc", int'(bus.blink), 1);
        step(30);
        bus.run = 1'b0;
        step(50); @(negedge clk);
        chk("pause_count", int'(bus.count), 30);
        chk("pause_blink", int'(bus.blink), 0);
        chk("pause_inc", int'(bus.inc), 0);
        bus.run = 1'b1;
        step(17); @(negedge clk);
        chk("resume_inc", int'(bus.inc), 1);
        step(21);
        bus.fast = 1'b1;
        @(negedge clk);
        chk("fast_count_20", int'(bus.count), 20);
        chk("fast_inc_same_cycle", int'(bus.inc), 1);
        step(1); @(negedge clk);
        chk("fast_wrap", int'(bus.count), 0);
        step(11); @(negedge clk);
        chk("fast_inc_12", int'(bus.inc), 1);
        step(1);
        bus.fast = 1'b0;
        step(47); @(negedge clk);
        chk("normal_restored", int'(bus.inc), 1);
        step(41);
        bus.realign = 1'b1;
        @(negedge clk);
        chk("realign_at_40", int'(bus.count), 40);
        chk("realign_no_inc", int'(bus.inc), 0);
        step(1);
        bus.realign = 1'b0;
        @(negedge clk);
        chk("realign_count", int'(bus.count), 0);
        chk("realign_blink", int'(bus.blink), 1);
        step(47); @(negedge clk);
        chk("inc_after_realign", int'(bus.inc), 1);
        bus.realign = 1'b1;
        @(negedge clk);
        chk("realign_term_inc", int'(bus.inc), 0);
        step(1);
        bus.realign = 1'b0;
        @(negedge clk);
        chk("realign_term_count", int'(bus.count), 0);
        step(10);
        reset_sync = 1'b1; bus.realign = 1'b1; bus.fast = 1'b1;
        step(1);
        reset_sync = 1'b0; bus.realign = 1'b0; bus.fast = 1'b0;
        @(negedge clk);
        chk("reset_wins_count", int'(bus.count), 0);
        chk("reset_wins_blink", int'(bus.blink), 1);
        chk("reset_wins_scan", int'(bus.scan_tick), 0);
        for (int i = 0; i < 3000; i++) begin
            step(1);
            reset_sync  = ($urandom_range(199) == 0);
            bus.realign = ($urandom_range(39) == 0);
            bus.run     = ($urandom_range(4) != 0);
            if ($urandom_range(29) == 0) bus.fast = ~bus.fast;
        end
        step(1);
        reset_sync = 1'b0; bus.realign = 1'b0;
        step(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
